regfile_dualwr: RTL and testbench
=================================

// Module: regfile_dualwr
// PURPOSE
//  Parametrised register file for the single-cycle CPU decode stage: two combinational read ports,
//  one core write-back port with a link (JAL) override, and one handshaked external write port
//  (I/O injection) buffered through a 1-entry pending slot. Provides optional write-to-read bypass,
//  two registered monitor taps for display/RAM, and a saturating conflict counter.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W
//  ZERO_REG  1   1: register 0 reads 0, writes to it ignored; 0: register 0 is ordinary
//  BYPASS    1   1: reads return data committing this cycle; 0: reads return stored contents
//  LINK_REG  31  register written by link_en (must be < 2**ADDR_W)
//  MON_A     24  index mirrored on mon_a
//  MON_B     26  index mirrored on mon_b
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       synchronous, active-high
//  rs_addr       in   ADDR_W  read port 1 address
//  rt_addr       in   ADDR_W  read port 2 address
//  rs_data       out  DATA_W  read port 1 data (combinational)
//  rt_data       out  DATA_W  read port 2 data (combinational)
//  wr_en         in   1       core write enable
//  wr_addr       in   ADDR_W  core write address
//  wr_data       in   DATA_W  core write data (ALU result or memory data, selected upstream)
//  link_en       in   1       JAL link write: writes link_data to LINK_REG, overrides wr_en/wr_addr
//  link_data     in   DATA_W  return address (PC+4)
//  ext_valid     in   1       external write request
//  ext_ready     out  1       external write slot free
//  ext_addr      in   ADDR_W  external write address
//  ext_data      in   DATA_W  external write data
//  mon_a         out  DATA_W  registered copy of reg[MON_A]
//  mon_b         out  DATA_W  registered copy of reg[MON_B]
//  conflict_cnt  out  16      saturating count of cycles the pending slot was blocked
// BEHAVIOUR
//  - Core write this cycle: link_en ? (LINK_REG, link_data) : wr_en ? (wr_addr, wr_data) : none.
//    Core write commits at the rising edge, 0-cycle latency.
//  - External accept: ext_valid && ext_ready at edge t loads pend_{addr,data}, pend_valid=1.
//  - Pending commit: if pend_valid and no core write to pend_addr this cycle, the pending entry
//    writes at the edge and pend_valid clears (unless a new accept reloads it the same edge).
//    If core writes pend_addr, the core write commits, the pending entry is held, and
//    conflict_cnt increments (saturating at 16'hFFFF). Retry occurs every cycle; the ext value
//    lands after the core value.
//  - Core and pending commits to different addresses occur on the same edge.
//  - ext_ready = !pend_valid || pend_commits_this_cycle; gives full throughput of 1 write/cycle
//    when there is no conflict. ext_ready is 0 while reset is high.
//  - ZERO_REG=1: any write to address 0 (core, link, or ext) is dropped; an ext entry to 0
//    still retires normally; reads of 0 return 0.
//  - Read value: ZERO_REG && addr==0 -> 0; else if BYPASS and core write to addr this cycle ->
//    core data; else if BYPASS and pending commits to addr this cycle -> pend_data; else reg[addr].
//  - mon_a/mon_b are updated every edge from pre-edge contents, so they lag a write by 1 cycle.
//  - Reset (edge with reset=1): all registers, mon_a, mon_b, conflict_cnt, pend_valid <= 0.
//    Any pending or in-flight ext write is discarded; core/link writes that cycle are ignored.
//  - With X-free inputs, an out-of-range LINK_REG/MON_* fails elaboration (generate check).
// TESTING
//  1 reset, then read all addrs -> 0; ext_ready=1 after the first non-reset edge; mon_a=mon_b=0.
//  2 wr_en addr 8 data 0x1234 with rs_addr=8 in the same cycle -> rs_data=0x1234 (BYPASS=1);
//    next cycle 0x1234 from the array; BYPASS=0 -> old value in the same cycle.
//  3 link_en with wr_en addr 5 -> reg31=link_data, reg5 unchanged; wr_en addr 0 data 0xFFFF ->
//    reads 0.
//  4 ext 25<-0xAA accepted at t, core writes 25<-0x55 at t+1 and t+2 -> conflict_cnt=2,
//    ext_ready=0 at t+1/t+2, reg25=0xAA after t+3; ext to 9 same cycle as core to 10 -> both written.
//  5 core writes 24<-0x77 -> mon_a=0x77 one cycle later; assert reset mid-pending ->
//    pend discarded, regs 0.

Source files
------------

// File: rtl/regfile_dualwr.sv
// Register file with two combinational read ports, a core write-back port with JAL link
// override, and a handshaked external write port buffered through a 1-entry pending slot.
module regfile_dualwr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int LINK_REG = 31,
  parameter int MON_A    = 24,
  parameter int MON_B    = 26
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              link_en_i,
  input  logic [DATA_W-1:0] link_data_i,
  input  logic              ext_valid_i,
  output logic              ext_ready_o,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_data_i,
  output logic [DATA_W-1:0] mon_a_o,
  output logic [DATA_W-1:0] mon_b_o,
  output logic [15:0]       conflict_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = LINK_REG[ADDR_W-1:0];

  if (LINK_REG < 0 || LINK_REG >= DEPTH) begin : g_bad_link
    $fatal(1, "regfile_dualwr: LINK_REG out of range");
  end
  if (MON_A < 0 || MON_A >= DEPTH || MON_B < 0 || MON_B >= DEPTH) begin : g_bad_mon
    $fatal(1, "regfile_dualwr: MON_A/MON_B out of range");
  end

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] mon_a_q, mon_b_q;

  logic              core_we, core_commit, conflict, pend_retire, pend_commit, ext_accept;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_data;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    core_we   = 1'b0;
    core_addr = wr_addr_i;
    core_data = wr_data_i;
    if (link_en_i) begin
      core_we   = 1'b1;
      core_addr = LINK_ADDR;
      core_data = link_data_i;
    end else if (wr_en_i) begin
      core_we = 1'b1;
    end
  end

  // A dropped write to register 0 never blocks the pending slot.
  assign core_commit = core_we && !(ZERO_REG && core_addr == '0);
  assign conflict    = pend_valid_q && core_commit && (core_addr == pend_addr_q);
  assign pend_retire = pend_valid_q && !conflict;
  assign pend_commit = pend_retire && !(ZERO_REG && pend_addr_q == '0);
  assign ext_ready_o = !reset_i && (!pend_valid_q || pend_retire);
  assign ext_accept  = ext_valid_i && ext_ready_o;

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_q[addr];
    if (ZERO_REG && addr == '0)                         val = '0;
    else if (BYPASS && core_commit && core_addr == addr)   val = core_data;
    else if (BYPASS && pend_commit && pend_addr_q == addr) val = pend_data_q;
    return val;
  endfunction

  always_comb begin
    rs_data_o = read_port(rs_addr_i);
    rt_data_o = read_port(rt_addr_i);
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    cnt_d        = cnt_q;
    if (pend_retire) pend_valid_d = 1'b0;
    if (ext_accept) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = ext_addr_i;
      pend_data_d  = ext_data_i;
    end
    if (conflict && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      cnt_q        <= '0;
      mon_a_q      <= '0;
      mon_b_q      <= '0;
      // NOTE: the array is reset because software relies on all registers reading 0 after reset.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      cnt_q        <= cnt_d;
      mon_a_q      <= regs_q[MON_A];
      mon_b_q      <= regs_q[MON_B];
      if (core_commit) regs_q[core_addr]   <= core_data;
      if (pend_commit) regs_q[pend_addr_q] <= pend_data_q;
    end
  end

  assign mon_a_o        = mon_a_q;
  assign mon_b_o        = mon_b_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_dualwr.sv
// Scoreboard bench for regfile_dualwr: expectations are queued as stimulus is driven and
// compared once the cycle's outputs have settled.
module tb_regfile_dualwr;

  typedef enum logic [2:0] {S_RS, S_RT, S_RS_NB, S_READY, S_MON_A, S_MON_B, S_CNT} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr, ext_addr;
  logic [31:0] wr_data, link_data, ext_data;
  logic        wr_en, link_en, ext_valid;
  logic [31:0] rs_data, rt_data, mon_a, mon_b;
  logic        ext_ready;
  logic [15:0] cnt;
  logic [31:0] rs_nb, rt_nb, mon_a_nb, mon_b_nb;
  logic        ready_nb;
  logic [15:0] cnt_nb;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  regfile_dualwr u_dut (
    .clock_i(clk), .reset_i(rst), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_data_o(rs_data), .rt_data_o(rt_data), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .link_en_i(link_en), .link_data_i(link_data),
    .ext_valid_i(ext_valid), .ext_ready_o(ext_ready), .ext_addr_i(ext_addr),
    .ext_data_i(ext_data), .mon_a_o(mon_a), .mon_b_o(mon_b), .conflict_cnt_o(cnt)
  );

  regfile_dualwr #(.BYPASS(1'b0)) u_dut_nb (
    .clock_i(clk), .reset_i(rst), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_data_o(rs_nb), .rt_data_o(rt_nb), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .link_en_i(link_en), .link_data_i(link_data),
    .ext_valid_i(ext_valid), .ext_ready_o(ready_nb), .ext_addr_i(ext_addr),
    .ext_data_i(ext_data), .mon_a_o(mon_a_nb), .mon_b_o(mon_b_nb), .conflict_cnt_o(cnt_nb)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input string tag, input sel_e sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_RS:    return rs_data;
      S_RT:    return rt_data;
      S_RS_NB: return rs_nb;
      S_READY: return {31'd0, ext_ready};
      S_MON_A: return mon_a;
      S_MON_B: return mon_b;
      default: return {16'd0, cnt};
    endcase
  endfunction

  // Settle, drain this cycle's expectations, then advance to just after the next edge.
  task automatic cycle();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; link_en = 1'b0; ext_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle();
    rs_addr = '0; rt_addr = '0; wr_addr = '0; ext_addr = '0;
    wr_data = '0; link_data = '0; ext_data = '0;

    // Reset: ready held low, then everything reads back zero.
    push_exp("ready_in_reset", S_READY, 0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    push_exp("ready_after_reset", S_READY, 1);
    push_exp("mon_a_reset", S_MON_A, 0);
    push_exp("mon_b_reset", S_MON_B, 0);
    push_exp("cnt_reset", S_CNT, 0);
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a);
      push_exp($sformatf("rs_reset_%0d", a), S_RS, 0);
      push_exp($sformatf("rt_reset_%0d", a), S_RT, 0);
      cycle();
    end

    // Same-cycle bypass versus stored contents.
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h1234; rs_addr = 5'd8;
    push_exp("bypass_core", S_RS, 32'h1234);
    push_exp("nobypass_core", S_RS_NB, 32'h0);
    cycle();
    idle();
    push_exp("stored_core", S_RS, 32'h1234);
    push_exp("stored_core_nb", S_RS_NB, 32'h1234);
    cycle();

    // Link overrides the core write; writes to register 0 are dropped.
    link_en = 1'b1; link_data = 32'h0000_0400;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD;
    rs_addr = 5'd31; rt_addr = 5'd5;
    push_exp("link_bypass", S_RS, 32'h400);
    push_exp("link_blocks_wr", S_RT, 32'h0);
    cycle();
    idle();
    push_exp("link_stored", S_RS, 32'h400);
    push_exp("reg5_untouched", S_RT, 32'h0);
    cycle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF; rs_addr = 5'd0;
    push_exp("zero_bypass", S_RS, 32'h0);
    cycle();
    idle();
    push_exp("zero_stored", S_RS, 32'h0);
    push_exp("zero_stored_nb", S_RS_NB, 32'h0);
    cycle();

    // External write blocked twice by core writes to the same register.
    ext_valid = 1'b1; ext_addr = 5'd25; ext_data = 32'hAA;
    push_exp("ext_accept_ready", S_READY, 1);
    cycle();
    ext_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h55; rs_addr = 5'd25;
    push_exp("blocked1_ready", S_READY, 0);
    push_exp("blocked1_rs", S_RS, 32'h55);
    push_exp("blocked1_cnt", S_CNT, 0);
    cycle();
    push_exp("blocked2_ready", S_READY, 0);
    push_exp("blocked2_cnt", S_CNT, 1);
    cycle();
    idle();
    push_exp("retry_ready", S_READY, 1);
    push_exp("retry_cnt", S_CNT, 2);
    push_exp("retry_bypass", S_RS, 32'hAA);
    push_exp("retry_nb_old", S_RS_NB, 32'h55);
    cycle();
    push_exp("ext_landed", S_RS, 32'hAA);
    push_exp("ext_landed_nb", S_RS_NB, 32'hAA);
    push_exp("cnt_hold", S_CNT, 2);
    cycle();

    // Pending and core commits to different registers on the same edge.
    ext_valid = 1'b1; ext_addr = 5'd9; ext_data = 32'h99;
    cycle();
    ext_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1010; rs_addr = 5'd9; rt_addr = 5'd10;
    push_exp("dual_ready", S_READY, 1);
    push_exp("dual_rs_bypass", S_RS, 32'h99);
    push_exp("dual_rt_bypass", S_RT, 32'h1010);
    push_exp("dual_rs_nb", S_RS_NB, 32'h0);
    cycle();
    idle();
    push_exp("dual_rs", S_RS, 32'h99);
    push_exp("dual_rt", S_RT, 32'h1010);
    push_exp("dual_cnt", S_CNT, 2);
    cycle();

    // Back-to-back external writes at full throughput.
    for (int i = 0; i < 3; i++) begin
      ext_valid = 1'b1; ext_addr = 5'(11 + i); ext_data = 32'(16'hE000 + i);
      push_exp($sformatf("stream_ready_%0d", i), S_READY, 1);
      cycle();
    end
    idle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      rs_addr = 5'(11 + i);
      push_exp($sformatf("stream_rd_%0d", i), S_RS, 32'(16'hE000 + i));
      cycle();
    end

    // Monitor taps lag the register by one edge.
    wr_en = 1'b1; wr_addr = 5'd24; wr_data = 32'h77;
    push_exp("mon_a_pre", S_MON_A, 0);
    cycle();
    wr_addr = 5'd26; wr_data = 32'h66;
    push_exp("mon_a_lag", S_MON_A, 0);
    push_exp("mon_b_pre", S_MON_B, 0);
    cycle();
    idle();
    push_exp("mon_a_val", S_MON_A, 32'h77);
    push_exp("mon_b_lag", S_MON_B, 0);
    cycle();
    push_exp("mon_b_val", S_MON_B, 32'h66);
    cycle();

    // Reset while an entry is pending and another request is presented.
    ext_valid = 1'b1; ext_addr = 5'd20; ext_data = 32'h20;
    cycle();
    ext_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h2020;
    push_exp("pre_rst_ready", S_READY, 0);
    cycle();
    idle();
    rst = 1'b1;
    ext_valid = 1'b1; ext_addr = 5'd21; ext_data = 32'h21;
    push_exp("pre_rst_cnt", S_CNT, 3);
    push_exp("rst_ready_low", S_READY, 0);
    cycle();
    rst = 1'b0; idle();
    rs_addr = 5'd20; rt_addr = 5'd21;
    push_exp("rst_reg20", S_RS, 0);
    push_exp("rst_reg21", S_RT, 0);
    push_exp("rst_cnt", S_CNT, 0);
    push_exp("rst_mon_a", S_MON_A, 0);
    push_exp("rst_ready", S_READY, 1);
    cycle();
    rt_addr = 5'd24;
    push_exp("rst_reg20_later", S_RS, 0);
    push_exp("rst_reg24", S_RT, 0);
    cycle();
    rs_addr = 5'd8;
    push_exp("rst_reg8", S_RS, 0);
    push_exp("rst_reg8_nb", S_RS_NB, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
